// File: rtl/instr_issue_queue.sv
// Circular instruction buffer feeding the CPU i_datain port.
// Issue FSM pops one word per unstalled cycle with optional NOP gap.
module instr_issue_queue #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int NOP_GAP = 0,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     run,
    input  logic                     stall,
    output logic [DATA_W-1:0]        i_datain,
    output logic                     issue_valid,
    output logic [CNT_W-1:0]         issued_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t              state_q, state_d;
    logic [2:0]          gap_q, gap_d;
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                push, pop;

    assign full        = (level_q == LW'(DEPTH));
    assign empty       = (level_q == '0);
    assign level       = level_q;
    assign i_datain    = data_q;
    assign issue_valid = valid_q;
    assign issued_cnt  = cnt_q;

    assign push = wr_en && !full;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_d  = '0;
                valid_d = 1'b0;
                if (run && !stall) state_d = ISSUE;
            end
            ISSUE: begin
                if (!run) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    data_d  = '0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_q];
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (NOP_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = 3'(NOP_GAP);
                        end
                    end else begin
                        data_d  = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (!run) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    data_d  = '0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    gap_d   = gap_q - 3'd1;
                    // last bubble: next cycle may issue again
                    if (gap_q == 3'd1) state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d    = pop  ? rd_q + PW'(1) : rd_q;
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) mem_q[wr_q] <= wr_data;
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: three configurations against a queue model.
// Directed scenarios followed by randomized traffic.
module tb_instr_issue_queue;

    localparam int NI = 3;
    localparam int DEP [NI] = '{16, 4, 16};
    localparam int GP  [NI] = '{0, 0, 2};
    localparam int CW  [NI] = '{16, 2, 16};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, wr_en, run, stall;
    logic [31:0] wr_data;

    logic [31:0] d_a, d_b, d_c;
    logic        v_a, v_b, v_c, f_a, f_b, f_c, e_a, e_b, e_c;
    logic [4:0]  l_a, l_c;
    logic [2:0]  l_b;
    logic [15:0] c_a, c_c;
    logic [1:0]  c_b;

    instr_issue_queue #(.DATA_W(32), .DEPTH(16), .NOP_GAP(0), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_a), .empty(e_a), .level(l_a), .run(run), .stall(stall),
        .i_datain(d_a), .issue_valid(v_a), .issued_cnt(c_a));

    instr_issue_queue #(.DATA_W(32), .DEPTH(4), .NOP_GAP(0), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_b), .empty(e_b), .level(l_b), .run(run), .stall(stall),
        .i_datain(d_b), .issue_valid(v_b), .issued_cnt(c_b));

    instr_issue_queue #(.DATA_W(32), .DEPTH(16), .NOP_GAP(2), .CNT_W(16)) u_c (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_c), .empty(e_c), .level(l_c), .run(run), .stall(stall),
        .i_datain(d_c), .issue_valid(v_c), .issued_cnt(c_c));

    logic [31:0] od [NI];
    logic [31:0] oc [NI];
    logic [31:0] ol [NI];
    logic        ov [NI];
    logic        of_ [NI];
    logic        oe [NI];

    assign od[0] = d_a;  assign od[1] = d_b;  assign od[2] = d_c;
    assign ov[0] = v_a;  assign ov[1] = v_b;  assign ov[2] = v_c;
    assign of_[0] = f_a; assign of_[1] = f_b; assign of_[2] = f_c;
    assign oe[0] = e_a;  assign oe[1] = e_b;  assign oe[2] = e_c;
    assign oc[0] = 32'(c_a); assign oc[1] = 32'(c_b); assign oc[2] = 32'(c_c);
    assign ol[0] = 32'(l_a); assign ol[1] = 32'(l_b); assign ol[2] = 32'(l_c);

    // reference model: a word queue plus issue bookkeeping per instance
    logic [31:0] mq [NI][$];
    bit          mrun [NI];
    int          mgap [NI];
    logic [31:0] mout [NI];
    bit          mv [NI];
    int          mcnt [NI];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < NI; m++) begin
            if (reset) begin
                mq[m].delete();
                mrun[m] = 0; mgap[m] = 0; mout[m] = 0; mv[m] = 0; mcnt[m] = 0;
            end else begin
                bit can_push;
                can_push = wr_en && (mq[m].size() < DEP[m]);
                if (!mrun[m]) begin
                    if (run && !stall) mrun[m] = 1;
                    mout[m] = 0; mv[m] = 0;
                end else if (!run) begin
                    mrun[m] = 0; mgap[m] = 0; mout[m] = 0; mv[m] = 0;
                end else if (!stall) begin
                    if (mgap[m] > 0) begin
                        mgap[m]--; mout[m] = 0; mv[m] = 0;
                    end else if (mq[m].size() > 0) begin
                        mout[m] = mq[m].pop_front();
                        mv[m]   = 1;
                        mcnt[m] = (mcnt[m] + 1) % (1 << CW[m]);
                        mgap[m] = GP[m];
                    end else begin
                        mout[m] = 0; mv[m] = 0;
                    end
                end
                if (can_push) mq[m].push_back(wr_data);
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("data%0d", m),  od[m],          mout[m]);
            chk($sformatf("valid%0d", m), 32'(ov[m]),     32'(mv[m]));
            chk($sformatf("cnt%0d", m),   oc[m],          32'(mcnt[m]));
            chk($sformatf("level%0d", m), ol[m],          32'(mq[m].size()));
            chk($sformatf("full%0d", m),  32'(of_[m]),
                32'(mq[m].size() == DEP[m]));
            chk($sformatf("empty%0d", m), 32'(oe[m]),     32'(mq[m].size() == 0));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    logic [31:0] W  [4] = '{32'h8C010001, 32'h8C020002, 32'h8C040003, 32'h8C050004};
    logic [31:0] GE [6] = '{32'h8C010001, 0, 0, 32'h20232C00, 0, 0};
    logic        GV [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1; wr_en = 1; run = 1; stall = 0; wr_data = 32'hFFFF_FFFF;
        step(); step();
        chk("rst_data", d_a, 0);
        chk("rst_valid", 32'(v_a), 0);
        chk("rst_level", 32'(l_a), 0);
        chk("rst_empty", 32'(e_a), 1);
        chk("rst_cnt", 32'(c_a), 0);
        reset = 0; wr_en = 0; run = 0;

        // in-order issue, fill and drop on the 4-deep instance
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_data = W[i]; step();
        end
        chk("full_b", 32'(f_b), 1);
        wr_data = 32'hDEADBEEF; step();
        chk("drop_level_b", 32'(l_b), 4);
        chk("level_a", 32'(l_a), 5);
        wr_en = 0; run = 1; step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("order_a", d_a, W[i]);
            chk("order_va", 32'(v_a), 1);
            chk("order_b", d_b, W[i]);
        end
        step();
        chk("fifth_a", d_a, 32'hDEADBEEF);
        chk("bubble_vb", 32'(v_b), 0);
        chk("wrap0_b", 32'(c_b), 0);
        step();
        chk("drain_va", 32'(v_a), 0);
        chk("drain_ca", 32'(c_a), 5);
        chk("drain_ea", 32'(e_a), 1);
        wr_en = 1; wr_data = 32'h0BADF00D; step();
        wr_en = 0; step();
        chk("wrap1_b", 32'(c_b), 1);
        chk("late_b", d_b, 32'h0BADF00D);

        // NOP gap pattern
        reset = 1; run = 0; step();
        reset = 0;
        wr_en = 1; wr_data = 32'h8C010001; step();
        wr_data = 32'h20232C00; step();
        wr_en = 0; run = 1; step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("gap_data", d_c, GE[i]);
            chk("gap_valid", 32'(v_c), 32'(GV[i]));
        end

        // stall hold, then run drop during a gap
        reset = 1; run = 0; step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_data = W[i]; step();
        end
        wr_en = 0; run = 1; step();
        step(); step();
        chk("pre_stall", d_a, W[1]);
        stall = 1; wr_en = 1; wr_data = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            step();
            wr_en = 0;
            chk("stall_data", d_a, W[1]);
            chk("stall_valid", 32'(v_a), 1);
            chk("stall_cnt", 32'(c_a), 2);
        end
        chk("stall_level", 32'(l_a), 2);
        stall = 0; step();
        chk("resume", d_a, W[2]);
        step();
        chk("gap_pop_c", d_c, W[1]);
        run = 0; step();
        chk("drop_vc", 32'(v_c), 0);
        chk("drop_lc", 32'(l_c), 2);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 149) == 0);
            wr_en   = ($urandom_range(0, 99) < (i < 400 ? 70 : 35));
            wr_data = $urandom();
            run     = ($urandom_range(0, 11) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
